sprite_blitter: RTL and testbench
=================================

SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 Parameter SPR_W, default 32, sprite width in pixels (power of two).
REQ-002 Parameter SPR_H, default 32, sprite height in pixels (power of two).
REQ-003 Parameter FB_W, default 320, frame buffer width in pixels.
REQ-004 Parameter FB_H, default 240, frame buffer height in pixels.
REQ-005 Port vga_clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-006 Port Reset  in  1  synchronous, active-high reset.
REQ-007 Port start  in  1  request one blit; sampled only in IDLE.
REQ-008 Port pos_x  in  9  sprite top-left x in frame-buffer pixels, unsigned.
REQ-009 Port pos_y  in  8  sprite top-left y in frame-buffer pixels, unsigned.
REQ-010 Port spr_addr  out  10  sprite ROM address, sy*SPR_W+sx.
REQ-011 Port spr_q  in  3  sprite ROM palette index, valid one cycle after spr_addr.
REQ-012 Port fb_addr  out  17  frame buffer write address, y*FB_W+x.
REQ-013 Port fb_data  out  3  palette index written to the frame buffer.
REQ-014 Port fb_we  out  1  frame buffer write enable, one write per high cycle.
REQ-015 Port busy  out  1  high while a blit is in progress.
REQ-016 Port done  out  1  single-cycle pulse at blit completion.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE -> RUN when start=1; pos_x/pos_y SHALL be latched on that edge, sx=sy=0.
REQ-019 start SHALL be ignored in RUN, DRAIN and DONE; inputs pos_x/pos_y changing mid-blit SHALL have no effect.
REQ-020 In RUN, spr_addr SHALL equal sy*SPR_W+sx; sx increments every cycle, wraps to 0 at SPR_W-1 with sy incrementing (raster order).
REQ-021 RUN -> DRAIN on the cycle issuing address SPR_W*SPR_H-1; RUN SHALL last exactly SPR_W*SPR_H cycles.
REQ-022 A one-stage pipeline register SHALL carry (valid, sx, sy) so each ROM result pairs with its own coordinates.
REQ-023 fb_we SHALL be high in the cycle after a RUN address iff spr_q != 0 and pos_x+sx < FB_W and pos_y+sy < FB_H.
REQ-024 Index 0 is transparent: no write SHALL occur for it.
REQ-025 Coordinate sums SHALL be computed at 10 bits so overflow past 511/255 is clipped, never wrapped onto the screen.
REQ-026 When fb_we=1, fb_addr SHALL be (pos_y+sy)*FB_W+(pos_x+sx) and fb_data SHALL equal spr_q; when fb_we=0 their values are don't-care.
REQ-027 DRAIN SHALL last one cycle (final pixel's write), then DONE for one cycle, then IDLE.
REQ-028 busy SHALL be 1 in RUN and DRAIN, 0 in IDLE and DONE; done SHALL be 1 only in DONE.
REQ-029 Start accepted at edge k: busy high cycles k+1..k+N+1, done high cycle k+N+2, N=SPR_W*SPR_H; throughput one pixel per cycle.
REQ-030 start held high continuously SHALL start a new blit from the IDLE cycle after DONE (back-to-back gap of one IDLE cycle).

Reset
REQ-031 On a Reset edge state SHALL become IDLE, counters and pipeline valid SHALL clear.
REQ-032 After reset: busy=0, done=0, fb_we=0, spr_addr=0; fb_addr=0 and fb_data=0.
REQ-033 Reset mid-blit SHALL abort without further writes from the cycle after the reset edge and without a done pulse.
REQ-034 Reset has priority over start in the same cycle.

Verification
REQ-035 Blit at (0,0) with ROM = all index 5 -> 1024 writes, fb_addr 0..31, 320..351, ... 9920..9951, fb_data=5, done at cycle k+1026.
REQ-036 ROM with index 0 at even sx -> exactly 512 writes, none at even x; busy/done timing unchanged.
REQ-037 Blit at (300,230), ROM non-zero -> only x 300..319, y 230..239 written (200 writes), no wrapped addresses.
REQ-038 Blit at (500,250) -> zero writes, done still pulses at k+1026.
REQ-039 Reset asserted at cycle k+100 of a blit -> fb_we=0 thereafter, no done, busy=0; a new start then completes normally.
REQ-040 start pulsed during RUN and held through DONE -> ignored in RUN, second blit begins after one IDLE cycle with newly latched pos_x/pos_y.

Source files
------------

// File: rtl/sprite_blitter.sv
// Sprite blitter: walks an SPR_W x SPR_H sprite ROM in raster order and writes
// its non-transparent pixels into a FB_W x FB_H frame buffer at (pos_x, pos_y).
// Pixels that fall outside the frame buffer are clipped, never wrapped.
//
// Handshake: start is a level request sampled only in IDLE; the blit runs
// without back-pressure, one ROM address per cycle, and every fb_we-high
// cycle is exactly one frame-buffer write. done pulses one cycle when the
// final write has been issued.
module sprite_blitter #(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32,
  parameter int FB_W  = 320,
  parameter int FB_H  = 240
) (
  input  logic        vga_clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [8:0]  pos_x,
  input  logic [7:0]  pos_y,
  output logic [9:0]  spr_addr,
  input  logic [2:0]  spr_q,
  output logic [16:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        fb_we,
  output logic        busy,
  output logic        done,
  output logic [1:0]  o_dbg_state
);

  localparam int SX_W = $clog2(SPR_W);
  localparam int SY_W = $clog2(SPR_H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [SX_W-1:0]   r_sx;
  logic [SY_W-1:0]   r_sy;
  logic [8:0]        r_pos_x;
  logic [7:0]        r_pos_y;
  logic              r_p_valid;
  logic [SX_W-1:0]   r_p_sx;
  logic [SY_W-1:0]   r_p_sy;
  logic              w_last;
  logic [9:0]        w_x;
  logic [9:0]        w_y;
  logic              w_we;
  logic [16:0]       w_fb_addr;

  assign w_last = (r_sx == SX_W'(SPR_W - 1)) && (r_sy == SY_W'(SPR_H - 1));

  // State register; reset wins over any request in the same cycle.
  always_ff @(posedge vga_clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and status outputs.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Raster counters and position latch; position is captured only on accept.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_sx    <= '0;
      r_sy    <= '0;
      r_pos_x <= '0;
      r_pos_y <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pos_x <= pos_x;
            r_pos_y <= pos_y;
            r_sx    <= '0;
            r_sy    <= '0;
          end
        end
        S_RUN: begin
          r_sx <= r_sx + 1'b1;
          if (r_sx == SX_W'(SPR_W - 1)) r_sy <= r_sy + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // One-stage pipeline so each ROM result meets the coordinates that fetched it.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_p_valid <= 1'b0;
      r_p_sx    <= '0;
      r_p_sy    <= '0;
    end else begin
      r_p_valid <= (r_state == S_RUN);
      r_p_sx    <= r_sx;
      r_p_sy    <= r_sy;
    end
  end

  // Sums are 10 bits wide so a sprite hanging past 511/255 compares as
  // off-screen instead of wrapping back to the left/top edge.
  assign w_x       = {1'b0, r_pos_x} + 10'(r_p_sx);
  assign w_y       = {2'b0, r_pos_y} + 10'(r_p_sy);
  assign w_we      = r_p_valid && (spr_q != 3'd0) &&
                     (w_x < 10'(FB_W)) && (w_y < 10'(FB_H));
  assign w_fb_addr = 17'(w_y) * 17'(FB_W) + 17'(w_x);

  // Address/data are zeroed when no write happens so idle outputs are clean.
  assign fb_we       = w_we;
  assign fb_addr     = w_we ? w_fb_addr : 17'd0;
  assign fb_data     = w_we ? spr_q : 3'd0;
  assign spr_addr    = 10'({r_sy, r_sx});
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sprite_blitter.sv
// Testbench for sprite_blitter: ROM model, scoreboard of expected writes,
// and busy/done timing profile checks across directed and random blits.
module tb_sprite_blitter;

  localparam int SPR_W = 32;
  localparam int SPR_H = 32;
  localparam int FB_W  = 320;
  localparam int FB_H  = 240;
  localparam int N     = SPR_W * SPR_H;

  // ---------------- clock / reset / DUT ----------------
  logic        vga_clk = 1'b0;
  logic        Reset   = 1'b1;
  logic        start   = 1'b0;
  logic [8:0]  pos_x   = '0;
  logic [7:0]  pos_y   = '0;
  logic [9:0]  spr_addr;
  logic [2:0]  spr_q   = '0;
  logic [16:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  always #5 vga_clk = ~vga_clk;

  sprite_blitter #(.SPR_W(SPR_W), .SPR_H(SPR_H), .FB_W(FB_W), .FB_H(FB_H)) dut (
    .vga_clk    (vga_clk),
    .Reset      (Reset),
    .start      (start),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .spr_addr   (spr_addr),
    .spr_q      (spr_q),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_we      (fb_we),
    .busy       (busy),
    .done       (done),
    .o_dbg_state(dbg_state)
  );

  // Synchronous sprite ROM: data one cycle after address.
  logic [2:0] rom [0:N-1];
  always @(posedge vga_clk) spr_q <= rom[spr_addr];

  // ---------------- scoreboard ----------------
  int         total  = 0;
  int         bad    = 0;
  int         wr_cnt = 0;
  int         exp_n  = 0;
  logic [19:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge vga_clk) begin
    if (fb_we) begin
      logic [19:0] e;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d data %0d expected no write",
                 fb_addr, fb_data);
      end else begin
        e = exp_q.pop_front();
        chk("fb_addr", int'(fb_addr), int'(e[19:3]));
        chk("fb_data", int'(fb_data), int'(e[2:0]));
      end
    end
  end

  // ---------------- reference model ----------------
  // mode 0: all 5; 1: 0 at even sx, else 1..7; 2: random 1..7; 3: random 0..7
  task automatic fill_rom(input int mode);
    for (int y = 0; y < SPR_H; y++) begin
      for (int x = 0; x < SPR_W; x++) begin
        case (mode)
          0:       rom[y*SPR_W+x] = 3'd5;
          1:       rom[y*SPR_W+x] = (x % 2 == 0) ? 3'd0 : 3'($urandom_range(1, 7));
          2:       rom[y*SPR_W+x] = 3'($urandom_range(1, 7));
          default: rom[y*SPR_W+x] = 3'($urandom_range(0, 7));
        endcase
      end
    end
  endtask

  // Expected writes: raster walk of the sprite, skipping transparent and off-screen pixels.
  task automatic expect_blit(input int px, input int py);
    wr_cnt = 0;
    exp_n  = 0;
    for (int y = 0; y < SPR_H; y++) begin
      for (int x = 0; x < SPR_W; x++) begin
        int sx_abs = px + x;
        int sy_abs = py + y;
        logic [2:0] pix = rom[y*SPR_W+x];
        if (pix != 3'd0 && sx_abs < FB_W && sy_abs < FB_H) begin
          exp_q.push_back({17'(sy_abs * FB_W + sx_abs), pix});
          exp_n++;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic launch(input int px, input int py);
    @(negedge vga_clk);
    pos_x = 9'(px);
    pos_y = 8'(py);
    start = 1'b1;
    expect_blit(px, py);
    @(posedge vga_clk);
  endtask

  // Watches N+3 cycles after the accepting edge; disturbs pos_x/pos_y mid-blit.
  task automatic watch(input bit hold, input int npx, input int npy, input int want);
    int bad_at = 0;
    for (int i = 1; i <= N + 3; i++) begin
      @(negedge vga_clk);
      if (i == 1 && !hold) start = 1'b0;
      if (i == 3) begin
        pos_x = hold ? 9'(npx) : 9'($urandom);
        pos_y = hold ? 8'(npy) : 8'($urandom);
      end
      if (i > 1 && i <= N && hold && (i % 97 == 0)) start = 1'b1;
      if ((busy !== (i <= N + 1)) || (done !== (i == N + 2)))
        if (bad_at == 0) bad_at = i;
    end
    chk("busy_done_profile_first_bad_cycle", bad_at, 0);
    chk("write_count", wr_cnt, exp_n);
    if (want >= 0) chk("spec_write_count", wr_cnt, want);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int a = 0; a < N; a++) rom[a] = 3'd0;

    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_fb_we", int'(fb_we), 0);
    chk("reset_spr_addr", int'(spr_addr), 0);
    chk("reset_fb_addr", int'(fb_addr), 0);
    chk("reset_fb_data", int'(fb_data), 0);
    start = 1'b1;   // reset must win over start
    @(posedge vga_clk);
    #1;
    chk("reset_over_start_busy", int'(busy), 0);
    @(negedge vga_clk);
    start = 1'b0;
    Reset = 1'b0;
    repeat (2) @(negedge vga_clk);
    chk("idle_busy", int'(busy), 0);

    // Directed blits
    fill_rom(0); launch(0, 0);     watch(1'b0, 0, 0, 1024);
    fill_rom(1); launch(0, 0);     watch(1'b0, 0, 0, 512);
    fill_rom(2); launch(300, 230); watch(1'b0, 0, 0, 200);
    launch(500, 250);              watch(1'b0, 0, 0, 0);

    // Random blits
    for (int r = 0; r < 3; r++) begin
      fill_rom(3);
      launch($urandom_range(0, 511), $urandom_range(0, 255));
      watch(1'b0, 0, 0, -1);
    end

    // Abort mid-blit with reset
    begin
      int flag = 0;
      fill_rom(2);
      launch($urandom_range(0, 200), $urandom_range(0, 150));
      for (int i = 1; i < 100; i++) begin
        @(negedge vga_clk);
        if (i == 1) start = 1'b0;
      end
      @(negedge vga_clk);
      Reset = 1'b1;
      @(posedge vga_clk);
      #1;
      exp_q.delete();
      for (int j = 1; j <= 30; j++) begin
        @(negedge vga_clk);
        if (j == 3) Reset = 1'b0;
        if (busy || done) flag = 1;
      end
      chk("abort_no_busy_or_done", flag, 0);
      chk("abort_state_idle", int'(dbg_state), 0);
      chk("abort_spr_addr", int'(spr_addr), 0);
    end
    fill_rom(3);
    launch($urandom_range(0, 320), $urandom_range(0, 240));
    watch(1'b0, 0, 0, -1);

    // start held through a blit: second blit after one IDLE cycle with new position
    begin
      int px2 = $urandom_range(0, 300);
      int py2 = $urandom_range(0, 220);
      fill_rom(3);
      launch($urandom_range(0, 300), $urandom_range(0, 220));
      watch(1'b1, px2, py2, -1);
      expect_blit(px2, py2);
      @(posedge vga_clk);
      watch(1'b0, 0, 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
